// File: rtl/prbs_gen_chk.sv
// Configurable Fibonacci-LFSR PRBS generator plus a self-synchronising receive checker
// with lock FSM, windowed loss-of-lock detection and a saturating error counter.
`timescale 1ns/1ps
module prbs_gen_chk #(
    parameter int                WIDTH      = 9,
    parameter int                TAP        = 5,
    parameter logic [WIDTH-1:0]  SEED       = WIDTH'(9'h0A1),
    parameter int                LOCK_THR   = 32,
    parameter int                WIN_LEN    = 64,
    parameter int                UNLOCK_THR = 16,
    parameter int                CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gen_en,
    input  logic             inj_err,
    output logic             gen_bit,
    input  logic             rx_valid,
    input  logic             rx_bit,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int MW      = $clog2(LOCK_THR + 1);
    localparam int WW      = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int BAD_MAX = (UNLOCK_THR > WIN_LEN) ? UNLOCK_THR : WIN_LEN;
    localparam int BW      = $clog2(BAD_MAX + 1);

    localparam logic [MW-1:0] LOCK_LAST  = MW'(LOCK_THR - 1);
    localparam logic [WW-1:0] WIN_LAST   = WW'(WIN_LEN - 1);
    localparam logic [BW-1:0] UNLOCK_LIM = BW'(UNLOCK_THR);

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    logic [WIDTH-1:0] r_gen;
    logic             r_gen_bit;
    logic [WIDTH-1:0] r_chk;
    state_t           r_state;
    logic [MW-1:0]    r_match_cnt;
    logic [WW-1:0]    r_win_cnt;
    logic [BW-1:0]    r_bad_cnt;
    logic             r_err_pulse;
    logic [CNT_W-1:0] r_err_cnt;

    logic             w_gen_fb;
    logic             w_pred;
    logic             w_mis;
    logic             w_chk_nz;
    logic [BW-1:0]    w_bad_nxt;
    logic             w_cnt_inc;

    assign w_gen_fb  = r_gen[WIDTH-1] ^ r_gen[TAP-1];
    assign w_pred    = r_chk[WIDTH-1] ^ r_chk[TAP-1];
    assign w_mis     = rx_bit ^ w_pred;
    assign w_chk_nz  = |r_chk;
    assign w_bad_nxt = r_bad_cnt + BW'(w_mis);
    assign w_cnt_inc = rx_valid && (r_state == ST_LOCKED) && w_mis;

    // Injection only flips the output bit; the LFSR state keeps the clean sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gen     <= SEED;
            r_gen_bit <= SEED[0];
        end else if (gen_en) begin
            r_gen     <= {r_gen[WIDTH-2:0], w_gen_fb};
            r_gen_bit <= w_gen_fb ^ inj_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chk       <= '0;
            r_state     <= ST_UNLOCKED;
            r_match_cnt <= '0;
            r_win_cnt   <= '0;
            r_bad_cnt   <= '0;
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= 1'b0;
            if (rx_valid) begin
                r_chk <= {r_chk[WIDTH-2:0], rx_bit};
                if (r_state == ST_UNLOCKED) begin
                    // An all-zero history predicts zero forever, so it never counts toward lock.
                    if (!w_mis && w_chk_nz) begin
                        r_match_cnt <= r_match_cnt + MW'(1);
                        if (r_match_cnt == LOCK_LAST) begin
                            r_state   <= ST_LOCKED;
                            r_win_cnt <= '0;
                            r_bad_cnt <= '0;
                        end
                    end else begin
                        r_match_cnt <= '0;
                    end
                end else begin
                    r_err_pulse <= w_mis;
                    if (r_win_cnt == WIN_LAST) begin
                        r_win_cnt <= '0;
                        r_bad_cnt <= '0;
                        if (w_bad_nxt >= UNLOCK_LIM) begin
                            r_state     <= ST_UNLOCKED;
                            r_match_cnt <= '0;
                        end
                    end else begin
                        r_win_cnt <= r_win_cnt + WW'(1);
                        r_bad_cnt <= w_bad_nxt;
                    end
                end
            end
        end
    end

    // A clear wins over a coincident increment, dropping that error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (clr_cnt) begin
            r_err_cnt <= '0;
        end else if (w_cnt_inc && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    assign gen_bit   = r_gen_bit;
    assign locked    = (r_state == ST_LOCKED);
    assign err_pulse = r_err_pulse;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Directed/randomised bench for prbs_gen_chk against a sequence-level reference model
// (PRBS recurrence over a bit history, lock/window rules counted with plain integers).
`timescale 1ns/1ps
module tb_prbs_gen_chk;
    localparam int         WIDTH      = 9;
    localparam int         TAP        = 5;
    localparam logic [8:0] SEED       = 9'h0A1;
    localparam int         LOCK_THR   = 32;
    localparam int         WIN_LEN    = 64;
    localparam int         UNLOCK_THR = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        gen_en, inj_err, rx_valid, rx_bit, clr_cnt;
    logic        gen_bit, locked, err_pulse;
    logic [15:0] err_cnt;
    logic        gen_bit4, locked4, err_pulse4;
    logic [3:0]  err_cnt4;

    int n_cmp = 0;
    int n_err = 0;

    prbs_gen_chk #(.WIDTH(WIDTH), .TAP(TAP), .SEED(SEED), .LOCK_THR(LOCK_THR),
                   .WIN_LEN(WIN_LEN), .UNLOCK_THR(UNLOCK_THR), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .gen_en(gen_en), .inj_err(inj_err), .gen_bit(gen_bit),
        .rx_valid(rx_valid), .rx_bit(rx_bit), .clr_cnt(clr_cnt), .locked(locked),
        .err_pulse(err_pulse), .err_cnt(err_cnt));

    prbs_gen_chk #(.WIDTH(WIDTH), .TAP(TAP), .SEED(SEED), .LOCK_THR(LOCK_THR),
                   .WIN_LEN(WIN_LEN), .UNLOCK_THR(UNLOCK_THR), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .gen_en(gen_en), .inj_err(inj_err), .gen_bit(gen_bit4),
        .rx_valid(rx_valid), .rx_bit(rx_bit), .clr_cnt(clr_cnt), .locked(locked4),
        .err_pulse(err_pulse4), .err_cnt(err_cnt4));

    always #5 clk = ~clk;

    // Reference model state
    logic ghist[$];
    logic rhist[$];
    logic m_gen;
    int   m_locked, m_match, m_win, m_bad, m_pulse, m_cnt, m_cnt4;
    logic prev_ge;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ghist.delete();
        rhist.delete();
        for (int i = WIDTH - 1; i >= 0; i--) ghist.push_back(SEED[i]);
        for (int i = 0; i < WIDTH; i++) rhist.push_back(1'b0);
        m_gen = SEED[0];
        m_locked = 0; m_match = 0; m_win = 0; m_bad = 0;
        m_pulse = 0; m_cnt = 0; m_cnt4 = 0;
        prev_ge = 1'b0;
    endtask

    task automatic model_step(input logic ge, input logic inj, input logic rv,
                              input logic rb, input logic clr);
        logic x, pred, mis, nz;
        int   pulse;
        if (ge) begin
            // x[n] = x[n-WIDTH] ^ x[n-TAP]
            x = ghist[ghist.size() - WIDTH] ^ ghist[ghist.size() - TAP];
            ghist.push_back(x);
            void'(ghist.pop_front());
            m_gen = x ^ inj;
        end
        pulse = 0;
        if (rv) begin
            pred = rhist[0] ^ rhist[WIDTH - TAP];
            mis  = rb ^ pred;
            nz   = 1'b0;
            foreach (rhist[i]) nz |= rhist[i];
            if (m_locked == 0) begin
                if (!mis && nz) begin
                    m_match++;
                    if (m_match == LOCK_THR) begin
                        m_locked = 1; m_win = 0; m_bad = 0;
                    end
                end else begin
                    m_match = 0;
                end
            end else begin
                m_win++;
                if (mis) begin
                    m_bad++;
                    pulse = 1;
                end
                if (m_win == WIN_LEN) begin
                    if (m_bad >= UNLOCK_THR) begin
                        m_locked = 0; m_match = 0;
                    end
                    m_win = 0; m_bad = 0;
                end
            end
            rhist.push_back(rb);
            void'(rhist.pop_front());
        end
        m_pulse = pulse;
        if (clr) begin
            m_cnt = 0; m_cnt4 = 0;
        end else if (pulse != 0) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt4 < 15) m_cnt4++;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".gen_bit"},    gen_bit,    m_gen);
        chk({tag, ".locked"},     locked,     m_locked);
        chk({tag, ".err_pulse"},  err_pulse,  m_pulse);
        chk({tag, ".err_cnt"},    err_cnt,    m_cnt);
        chk({tag, ".gen_bit4"},   gen_bit4,   m_gen);
        chk({tag, ".locked4"},    locked4,    m_locked);
        chk({tag, ".err_pulse4"}, err_pulse4, m_pulse);
        chk({tag, ".err_cnt4"},   err_cnt4,   m_cnt4);
    endtask

    task automatic cycle(input logic ge, input logic inj, input logic rv,
                         input logic rb, input logic clr);
        gen_en = ge; inj_err = inj; rx_valid = rv; rx_bit = rb; clr_cnt = clr;
        model_step(ge, inj, rv, rb, clr);
        @(posedge clk); #1;
        check_all("cyc");
    endtask

    // External loopback: last cycle's gen_bit is received, qualified by last cycle's gen_en.
    task automatic lb_cycle(input logic ge, input logic inj, input logic clr);
        logic rv, rb;
        rv = prev_ge;
        rb = gen_bit;
        prev_ge = ge;
        cycle(ge, inj, rv, rb, clr);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   exp4[4];
        int   n_valid, lock_at, pulses, unlocked_at, ever_locked;
        logic rb;

        exp4 = '{0, 1, 0, 1};
        rst = 1'b1;
        gen_en = 1'b0; inj_err = 1'b0; rx_valid = 1'b0; rx_bit = 1'b0; clr_cnt = 1'b0;
        model_reset();

        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        check_all("reset_hi");
        rst = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_rel.gen_bit", gen_bit, 1);

        // Generator sequence and lock in loopback
        n_valid = 0;
        lock_at = 0;
        for (int i = 0; i < 600; i++) begin
            if (prev_ge) n_valid++;
            lb_cycle(1'b1, 1'b0, 1'b0);
            if (i < 4) chk("first4", gen_bit, exp4[i]);
            if (locked && lock_at == 0) lock_at = n_valid;
        end
        chk("lock_within_41", (lock_at > 0 && lock_at <= WIDTH + LOCK_THR), 1);

        // Long clean run with random generator gaps
        for (int i = 0; i < 2000; i++)
            lb_cycle(($urandom_range(0, 3) != 0), 1'b0, 1'b0);
        chk("clean_err_cnt", err_cnt, 0);
        chk("clean_locked", locked, 1);

        // Single injected error yields three mismatches
        pulses = 0;
        lb_cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) begin
            lb_cycle(1'b1, 1'b0, 1'b0);
            if (err_pulse) pulses++;
        end
        chk("inj_pulses", pulses, 3);
        chk("inj_err_cnt", err_cnt, 3);
        chk("inj_locked", locked, 1);

        // Twenty injections: narrow counter saturates
        for (int k = 0; k < 20; k++) begin
            lb_cycle(1'b1, 1'b1, 1'b0);
            for (int i = 0; i < 69; i++) lb_cycle(1'b1, 1'b0, 1'b0);
        end
        chk("sat_err_cnt4", err_cnt4, 15);
        chk("sat_err_cnt16", err_cnt, 63);
        chk("sat_locked", locked, 1);

        // clr_cnt coincident with the first mismatch of an injected error
        lb_cycle(1'b1, 1'b1, 1'b0);
        lb_cycle(1'b1, 1'b0, 1'b1);
        chk("clr_coinc_cnt", err_cnt, 0);
        chk("clr_coinc_pulse", err_pulse, 1);
        for (int i = 0; i < 20; i++) lb_cycle(1'b1, 1'b0, 1'b0);
        chk("clr_after_cnt", err_cnt, 2);

        // Random data while locked forces loss of lock
        unlocked_at = 0;
        prev_ge = 1'b0;
        for (int i = 1; i <= 2 * WIN_LEN; i++) begin
            rb = 1'($urandom_range(0, 1));
            cycle(1'b0, 1'b0, 1'b1, rb, 1'b0);
            if (!locked && unlocked_at == 0) unlocked_at = i;
        end
        chk("unlock_within_128", (unlocked_at > 0), 1);

        // All-zero input never locks
        ever_locked = 0;
        for (int i = 0; i < 1000; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            if (locked) ever_locked = 1;
        end
        chk("zeros_never_lock", ever_locked, 0);

        // Relock, then asynchronous reset mid-stream
        for (int i = 0; i < 100; i++) lb_cycle(1'b1, 1'b0, 1'b0);
        chk("relock", locked, 1);
        rst = 1'b1;
        model_reset();
        #2;
        check_all("async_rst");
        gen_en = 1'b0; inj_err = 1'b0; rx_valid = 1'b0; rx_bit = 1'b0; clr_cnt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("rst_held");
        rst = 1'b0;
        lb_cycle(1'b1, 1'b0, 1'b0);
        chk("post_rst_first_bit", gen_bit, 0);
        for (int i = 0; i < 3; i++) lb_cycle(1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/prbs_gen_chk.md
# prbs_gen_chk

Parametrised PRBS generator and self-synchronising checker for link bring-up and BER measurement. It replaces the fixed PRBS9 generator with a configurable Fibonacci LFSR of any length and tap, single-bit error injection, and a receive checker. The checker has a lock state machine, a windowed loss-of-lock detector and a saturating error counter. It sits between the test-pattern mux and the serial datapath; the generator and checker share the polynomial but run independently.

## Interface
- WIDTH, 9: LFSR length (>= 3).
- TAP, 5: second feedback tap, 1-based (2 <= TAP < WIDTH). Feedback is state[WIDTH-1] ^ state[TAP-1].
- SEED, 9'h0A1: generator reset state, WIDTH bits. Must be nonzero.
- LOCK_THR, 32: consecutive counted matches needed to lock (>= WIDTH).
- WIN_LEN, 64: loss-of-lock window length, in valid bits.
- UNLOCK_THR, 16: mismatches within one window that force unlock.
- CNT_W, 16: error counter width.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- gen_en  in  1  advance the generator one bit.
- inj_err  in  1  invert the bit produced this gen_en cycle. Ignored when gen_en=0.
- gen_bit  out  1  registered generator output.
- rx_valid  in  1  rx_bit is valid this cycle.
- rx_bit  in  1  received bit.
- clr_cnt  in  1  synchronous clear of err_cnt.
- locked  out  1  checker is in LOCKED.
- err_pulse  out  1  registered; high one cycle per mismatch counted while LOCKED.
- err_cnt  out  CNT_W  saturating count of locked mismatches.

## Operation
- **Generator**
  - On gen_en: fb = g[WIDTH-1] ^ g[TAP-1]; g <= {g[WIDTH-2:0], fb}; gen_bit <= fb ^ inj_err.
  - Injection never corrupts g.
  - With gen_en=0, g and gen_bit hold.
- **Checker shift register r (WIDTH bits)**
  - On rx_valid: pred = r[WIDTH-1] ^ r[TAP-1]; mis = rx_bit ^ pred; r <= {r[WIDTH-2:0], rx_bit}.
  - r is loaded with received data, so the checker is self-synchronising.
  - In LOCKED, one flipped bit produces exactly 3 mismatches: when it arrives, and when it sits at TAP-1 and at WIDTH-1.
- **FSM, two states**
  - UNLOCKED:
    - match_cnt increments on a valid bit with mis=0 and r != 0; it clears to 0 on any other valid bit.
    - The r != 0 condition prevents lock on all-zero input.
    - When match_cnt reaches LOCK_THR, go to LOCKED and clear win_cnt and bad_cnt.
  - LOCKED:
    - Per valid bit: win_cnt increments; on mis, bad_cnt increments, err_pulse is set next cycle, and err_cnt increments.
    - When win_cnt reaches WIN_LEN-1 on a valid bit, evaluate bad_cnt including the current bit.
    - If bad_cnt >= UNLOCK_THR, go to UNLOCKED and clear match_cnt. Otherwise clear win_cnt and bad_cnt and stay LOCKED.
  - Mismatches in UNLOCKED never touch err_cnt or err_pulse.
- **err_cnt**
  - Saturates at 2^CNT_W-1 and holds.
  - clr_cnt has priority over a simultaneous increment: the result is 0 and that error is lost.
  - err_cnt is not cleared by lock or unlock transitions.
- The generator and checker share no state; loopback is external.

## Timing
- **Reset values:**
  - g=SEED, gen_bit=SEED[0].
  - r=0, FSM=UNLOCKED.
  - locked=0, err_pulse=0, err_cnt=0.
  - All internal counters 0.
- Reset asserted mid-operation aborts immediately and asynchronously. The first post-reset gen_en produces the seed's first feedback bit.
- gen_bit updates the cycle after gen_en (1-cycle latency).
- locked rises on the clock edge that completes the LOCK_THR-th counted match. It is visible the following cycle.
- err_pulse and err_cnt update one cycle after the mismatching rx_valid cycle.
- With rx_valid=0, all checker state holds. There is no timeout.
- On the unlock edge, an error on the final window bit still increments err_cnt.

## Test plan
- **Reset:** assert rst mid-stream -> gen_bit=1 (SEED[0]), locked=0, err_cnt=0, err_pulse=0 while rst high and after release.
- **Generator sequence:** defaults, gen_en held high -> first four gen_bit values 0,1,0,1. Period is 511 bits. The pattern repeats exactly at bit 512.
- **Lock:** loop gen_bit to rx_bit with rx_valid = delayed gen_en -> locked=1 within WIDTH+LOCK_THR = 41 valid bits. Then 2000 bits with err_cnt=0.
- **Injection:** locked loopback, one inj_err pulse -> exactly 3 err_pulse cycles, err_cnt=3, locked stays 1.
- **Loss of lock and zero input:** while locked, replace rx_bit with random data -> locked=0 after at most 2 windows (128 bits). All-zero input for 1000 bits -> locked never asserts.
- **Counter rules:** CNT_W=4, 20 injected errors -> err_cnt saturates at 15. clr_cnt coincident with an err_pulse increment -> err_cnt=0.
